spi_in_snapshot: RTL and testbench

- Parametrised SPI slave for the interlock input CPLD.
- On chip-select assertion it snapshots N_IN synchronised field inputs and frames them with a sequence header and a parity bit.
- It shifts the frame out on miso, MSB-first, to the master controller.
- Replaces the fixed 75-bit shift-out with selectable SPI mode, abort detection, frame status and integrity bits.

---
 rtl/spi_in_pkg.sv | 27 ++
 rtl/sync_edge.sv | 36 +++
 rtl/spi_in_snapshot.sv | 134 +++++++++++++
 tb/tb_spi_in_snapshot.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_in_pkg.sv
// Shared types and helpers for the interlock-input SPI snapshot slave.
package spi_in_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int frame_len(input int n_in, input int hdr_w);
        return hdr_w + n_in + 1;
    endfunction

    // Mode number is simply {CPOL, CPHA}.
    function automatic spi_mode_t mode_of(input bit cpol, input bit cpha);
        return spi_mode_t'({cpol, cpha});
    endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage synchroniser with registered rise/fall pulses, usable on a single pin or a bus.
module sync_edge #(
    parameter int              WIDTH     = 1,
    parameter int              STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] stage [STAGES];
    logic [WIDTH-1:0] q_d;

    // Edge pulses are registered so downstream logic sees a clean one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
            q_d  <= RESET_VAL;
            rise <= '0;
            fall <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
            q_d  <= stage[STAGES-1];
            rise <= stage[STAGES-1] & ~q_d;
            fall <= ~stage[STAGES-1] & q_d;
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_in_snapshot.sv
// SPI slave that snapshots the field inputs on chip-select and shifts out
// {sequence header, data_in[0..N_IN-1], even parity} MSB-first on miso.
module spi_in_snapshot
    import spi_in_pkg::*;
#(
    parameter int N_IN        = 75,
    parameter int HDR_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0
) (
    input  logic            pclk_50M,
    input  logic            rst_n,
    input  logic [N_IN-1:0] data_in,
    input  logic            spi_cs,
    input  logic            spi_clk,
    output logic            miso,
    output logic            miso_oe,
    output logic            busy,
    output logic            frame_done,
    output logic            frame_abort
);

    localparam int        L    = frame_len(N_IN, HDR_W);
    localparam int        CW   = $clog2(L + 1);
    localparam spi_mode_t MODE = mode_of(CPOL, CPHA);
    localparam bit LEAD_IS_FALL  = (MODE == MODE2) || (MODE == MODE3);
    localparam bit SHIFT_ON_LEAD = (MODE == MODE1) || (MODE == MODE3);

    logic            cs_rise, cs_fall, clk_rise, clk_fall;
    logic            cs_q_unused, clk_q_unused;
    logic [N_IN-1:0] data_sync, data_rise_unused, data_fall_unused;

    sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(pclk_50M), .rst_n(rst_n), .d(spi_cs),
        .q(cs_q_unused), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_clk_sync (
        .clk(pclk_50M), .rst_n(rst_n), .d(spi_clk),
        .q(clk_q_unused), .rise(clk_rise), .fall(clk_fall)
    );

    sync_edge #(.WIDTH(N_IN), .STAGES(SYNC_STAGES), .RESET_VAL({N_IN{1'b0}})) u_data_sync (
        .clk(pclk_50M), .rst_n(rst_n), .d(data_in),
        .q(data_sync), .rise(data_rise_unused), .fall(data_fall_unused)
    );

    logic lead_edge, trail_edge, shift_edge, count_edge, last_count;

    assign lead_edge  = LEAD_IS_FALL ? clk_fall : clk_rise;
    assign trail_edge = LEAD_IS_FALL ? clk_rise : clk_fall;
    assign shift_edge = SHIFT_ON_LEAD ? lead_edge : trail_edge;
    assign count_edge = SHIFT_ON_LEAD ? trail_edge : lead_edge;

    state_t           state;
    logic [L-1:0]     shreg;
    logic [CW-1:0]    bit_cnt;
    logic [HDR_W-1:0] seq;
    logic [N_IN-1:0]  data_rev;
    logic             parity;
    logic [L-1:0]     frame_word;

    // data_in[0] must leave right after the header, so it sits just below seq.
    always_comb begin
        data_rev = '0;
        for (int i = 0; i < N_IN; i++) data_rev[N_IN-1-i] = data_sync[i];
    end

    assign parity     = ^{seq, data_sync};
    assign frame_word = {seq, data_rev, parity};
    assign last_count = count_edge && (bit_cnt == CW'(L - 1));

    always_ff @(posedge pclk_50M) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            seq         <= '0;
            miso        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) state <= LOAD;
                end
                LOAD: begin
                    // CPHA=0 presents bit 0 now, so the register already holds bit 1 onward.
                    shreg   <= SHIFT_ON_LEAD ? frame_word : (frame_word << 1);
                    miso    <= SHIFT_ON_LEAD ? 1'b0 : frame_word[L-1];
                    bit_cnt <= '0;
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        miso        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_count) begin
                        frame_done <= 1'b1;
                        seq        <= seq + 1'b1;
                        miso       <= 1'b0;
                        state      <= cs_rise ? IDLE : DONE;
                    end else if (cs_rise) begin
                        frame_abort <= 1'b1;
                        miso        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        if (count_edge) bit_cnt <= bit_cnt + 1'b1;
                        if (shift_edge) begin
                            miso  <= shreg[L-1];
                            shreg <= shreg << 1;
                        end
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                    if (cs_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == LOAD) || (state == SHIFT);
    assign miso_oe = (state != IDLE);

endmodule

// File: tb/tb_spi_in_snapshot.sv
// Scoreboard bench: three slaves (mode 0 / mode 3 with 75 inputs, mode 0 with 4 inputs for seq wrap).
module tb_spi_in_snapshot;

    localparam int HDR = 8;
    localparam logic [2:0] IDLE_LVL = 3'b010;

    typedef struct {
        bit           is_abort;
        logic [127:0] frame;
        int           len;
    } ev_t;

    logic        pclk_50M = 1'b0;
    logic        rst_n;
    logic [74:0] din0, din1;
    logic [3:0]  din2;
    logic [2:0]  spi_cs, spi_clk, miso, miso_oe, busy, frame_done, frame_abort;

    ev_t          q0[$], q1[$], q2[$];
    logic [7:0]   seq_m [3];
    logic [127:0] rx [3];
    int           rx_n [3];
    int           checks = 0;
    int           failures = 0;

    ev_t          mon_e;
    bit           mon_ok;
    logic [127:0] mon_mask;

    always #10 pclk_50M = ~pclk_50M;

    spi_in_snapshot #(.N_IN(75), .HDR_W(8), .SYNC_STAGES(2), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .pclk_50M(pclk_50M), .rst_n(rst_n), .data_in(din0), .spi_cs(spi_cs[0]), .spi_clk(spi_clk[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .frame_abort(frame_abort[0])
    );

    spi_in_snapshot #(.N_IN(75), .HDR_W(8), .SYNC_STAGES(2), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .pclk_50M(pclk_50M), .rst_n(rst_n), .data_in(din1), .spi_cs(spi_cs[1]), .spi_clk(spi_clk[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .frame_abort(frame_abort[1])
    );

    spi_in_snapshot #(.N_IN(4), .HDR_W(8), .SYNC_STAGES(2), .CPOL(1'b0), .CPHA(1'b0)) dut2 (
        .pclk_50M(pclk_50M), .rst_n(rst_n), .data_in(din2), .spi_cs(spi_cs[2]), .spi_clk(spi_clk[2]),
        .miso(miso[2]), .miso_oe(miso_oe[2]), .busy(busy[2]),
        .frame_done(frame_done[2]), .frame_abort(frame_abort[2])
    );

    task automatic checkOutput(input string name, input int k, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s inst=%0d got=%0h want=%0h", name, k, got, want);
        end
    endtask

    // Reference frame: header MSB first, then data_in[0] upward, then even parity over all of it.
    function automatic logic [127:0] model_frame(input int n_in, input logic [74:0] d, input logic [7:0] s);
        logic [127:0] f = '0;
        for (int i = 0; i < HDR; i++) f[i] = s[HDR-1-i];
        for (int i = 0; i < n_in; i++) f[HDR+i] = d[i];
        f[HDR+n_in] = ^f;
        return f;
    endfunction

    function automatic logic [74:0] get_din(input int k);
        case (k)
            0:       return din0;
            1:       return din1;
            default: return {71'b0, din2};
        endcase
    endfunction

    task automatic randomize_din(input int k);
        case (k)
            0:       din0 = 75'({$urandom(), $urandom(), $urandom()});
            1:       din1 = 75'({$urandom(), $urandom(), $urandom()});
            default: din2 = 4'($urandom());
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_ev(input int k, input ev_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_ev(input int k, output ev_t e, output bit ok);
        ok = 1'b0;
        e.is_abort = 1'b0;
        e.frame = '0;
        e.len = 0;
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic capture(input int k);
        if (spi_cs[k] == 1'b0 && rx_n[k] < 128) begin
            rx[k][rx_n[k]] = miso[k];
            rx_n[k]++;
        end
    endtask

    // Both mode 0 and mode 3 masters sample miso on the rising spi_clk edge.
    always @(posedge spi_clk[0]) capture(0);
    always @(posedge spi_clk[1]) capture(1);
    always @(posedge spi_clk[2]) capture(2);

    always @(negedge pclk_50M) begin
        for (int k = 0; k < 3; k++) begin
            if (frame_done[k] || frame_abort[k]) begin
                pop_ev(k, mon_e, mon_ok);
                checkOutput("event_expected", k, 128'(mon_ok), 128'd1);
                if (mon_ok) begin
                    checkOutput("event_kind", k, 128'({frame_abort[k], frame_done[k]}),
                                128'({mon_e.is_abort, ~mon_e.is_abort}));
                    if (!mon_e.is_abort) begin
                        mon_mask = (128'd1 << mon_e.len) - 128'd1;
                        checkOutput("frame_bits", k, rx[k] & mon_mask, mon_e.frame);
                    end
                end
            end
        end
    end

    // One master transaction: n_clk full spi_clk periods; fewer than the frame length is an abort.
    task automatic applyStimulus(input int k, input int n_clk, input int half);
        ev_t e;
        int  len;
        len        = (k == 2) ? 13 : 84;
        e.len      = len;
        e.is_abort = (n_clk < len);
        e.frame    = model_frame(len - HDR - 1, get_din(k), seq_m[k]);
        push_ev(k, e);
        if (!e.is_abort) seq_m[k] = seq_m[k] + 8'd1;
        rx_n[k] = 0;
        rx[k]   = '0;
        spi_cs[k] = 1'b0;
        #200;
        for (int i = 0; i < n_clk; i++) begin
            spi_clk[k] = ~IDLE_LVL[k];
            #(half);
            spi_clk[k] = IDLE_LVL[k];
            #(half);
            if (i == 0) begin
                checkOutput("busy_oe_in_frame", k, 128'({busy[k], miso_oe[k]}), 128'(2'b11));
                randomize_din(k);
            end
        end
        checkOutput("busy_oe_end", k, 128'({busy[k], miso_oe[k]}), 128'({e.is_abort, 1'b1}));
        #100;
        spi_cs[k] = 1'b1;
        #300;
        checkOutput("pending_events", k, 128'(q_size(k)), 128'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        spi_cs  = 3'b111;
        spi_clk = IDLE_LVL;
        din0 = '0; din1 = '0; din2 = '0;
        for (int k = 0; k < 3; k++) begin seq_m[k] = 8'd0; rx[k] = '0; rx_n[k] = 0; end
        #3;
        #80;
        for (int k = 0; k < 3; k++)
            checkOutput("reset_outputs", k,
                        128'({miso[k], miso_oe[k], busy[k], frame_done[k], frame_abort[k]}), 128'd0);
        rst_n = 1'b1;
        #100;

        $display("[TB] scenario 1: mode 0 alternating pattern, 90 clocks");
        for (int i = 0; i < 75; i++) din0[i] = (i % 2 == 0);
        applyStimulus(0, 90, 150);
        checkOutput("header_seq0", 0, 128'(rx[0][7:0]), 128'd0);
        checkOutput("tail_zero", 0, 128'(rx[0][89:84]), 128'd0);

        $display("[TB] scenario 2: abort then full frame");
        randomize_din(0);
        applyStimulus(0, $urandom_range(1, 20), 150);
        randomize_din(0);
        applyStimulus(0, 84, 150);
        checkOutput("header_seq1", 0, 128'(rx[0][7:0]), 128'h80);

        $display("[TB] scenario 3: parity on mode 3 instance");
        din1 = '1;
        applyStimulus(1, 84, 150);
        checkOutput("parity_seq0", 1, 128'(rx[1][83]), 128'd1);
        din1 = '1;
        applyStimulus(1, 84, 150);
        checkOutput("parity_seq1", 1, 128'(rx[1][83]), 128'd0);

        $display("[TB] scenario 5: mode 3 with alternating pattern, then random frames");
        for (int i = 0; i < 75; i++) din1[i] = (i % 2 == 0);
        applyStimulus(1, 90, 150);
        for (int n = 0; n < 3; n++) begin
            randomize_din(1);
            applyStimulus(1, $urandom_range(1, 90), 150);
        end

        $display("[TB] scenario 4: sequence wrap on small instance");
        for (int f = 0; f < 256; f++) begin
            randomize_din(2);
            applyStimulus(2, 13, 120);
        end
        randomize_din(2);
        applyStimulus(2, 13, 120);
        checkOutput("wrap_header", 2, 128'(rx[2][7:0]), 128'd0);

        $display("[TB] scenario 6: reset at bit 40");
        randomize_din(0);
        spi_cs[0] = 1'b0;
        #200;
        for (int i = 0; i < 40; i++) begin
            spi_clk[0] = 1'b1;
            #150;
            spi_clk[0] = 1'b0;
            #150;
        end
        rst_n = 1'b0;
        @(posedge pclk_50M);
        #1;
        checkOutput("reset_midframe", 0,
                    128'({miso[0], miso_oe[0], busy[0], frame_done[0], frame_abort[0]}), 128'd0);
        for (int k = 0; k < 3; k++) seq_m[k] = 8'd0;
        spi_cs  = 3'bxxx;
        spi_clk = 3'bxxx;
        repeat (5) @(negedge pclk_50M);
        spi_cs  = 3'b111;
        spi_clk = IDLE_LVL;
        repeat (4) @(negedge pclk_50M);
        #3;
        rst_n = 1'b1;
        #400;
        checkOutput("idle_after_reset", 0, 128'({busy, miso_oe}), 128'd0);
        randomize_din(0);
        applyStimulus(0, 84, 150);
        checkOutput("header_after_reset", 0, 128'(rx[0][7:0]), 128'd0);

        for (int k = 0; k < 3; k++) checkOutput("final_pending", k, 128'(q_size(k)), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
